pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer for the monocycle core. Holds the current PC and drives pc4 to the next-PC selection mux. Commits that mux's selected next_pc when the instruction retires. Performs a request/acknowledge fetch from instruction memory and presents the instruction to decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles in FETCH without imem_ack before bus-timeout fault; 0 disables the timeout
ADDR_W, 32, PC/address width; data width fixed at 32

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  allow new fetches
next_pc  input  ADDR_W  selected next PC from the jump/branch mux
pc  output  ADDR_W  current PC
pc4  output  ADDR_W  pc + 4, combinational, to jump mux
imem_req  output  1  fetch request
imem_addr  output  ADDR_W  fetch address, equals pc
imem_ack  input  1  memory has imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
instr  output  32  registered instruction to decode
instr_valid  output  1  instr valid, awaiting retirement
instr_done  input  1  decode/execute retires instr this cycle
fault  output  1  sticky fault flag
fault_code  output  2  01 misaligned next_pc, 10 fetch timeout, 00 none
retired_count  output  32  retired-instruction counter

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fault=0, fault_code=00, retired_count=0, timer=0.
- pc4 = pc + 4 modulo 2^ADDR_W; wraps at 32'hFFFF_FFFC -> 0. imem_addr = pc at all times.
- States: IDLE, FETCH, EXEC, FAULT.
- IDLE:
  - imem_req=0.
  - enable=1 -> FETCH next cycle; otherwise stay.
- FETCH:
  - imem_req=1.
  - imem_ack=1 in any FETCH cycle, including the first: instr<=imem_rdata, timer cleared, -> EXEC. instr_valid=1 from the following cycle.
  - Best-case latency: enable sampled at edge N, req high in cycle N+1, ack in N+1, instr_valid high in N+2.
  - Once raised, imem_req is held until ack or timeout, regardless of enable.
  - No ack: timer increments. If TIMEOUT!=0 and timer reaches TIMEOUT with no ack -> FAULT, fault_code=10.
  - An ack arriving on the timeout cycle wins; no fault.
- EXEC:
  - instr_valid=1, imem_req=0.
  - Wait for instr_done.
  - On instr_done with next_pc[1:0]!=0: pc unchanged, -> FAULT, fault_code=01, retired_count not incremented.
  - On instr_done with aligned next_pc: pc<=next_pc, retired_count+=1 (wraps at 2^32), instr_valid drops next cycle. Then -> FETCH if enable=1, else IDLE.
  - next_pc=0 is legal; the mux default output is aligned.
- FAULT:
  - Sticky until rst_n: fault=1, imem_req=0, instr_valid=0.
  - pc and retired_count frozen.
- Ignored inputs:
  - imem_ack outside FETCH.
  - instr_done outside EXEC.
- Reset mid-fetch: asynchronous return to reset values. imem_req drops immediately, without waiting for a clock edge.
- Timer width: clog2(TIMEOUT+1), minimum 1 bit.

Decomposition:
- Shared package core_pkg:
  - state enum fetch_state_t {IDLE, FETCH, EXEC, FAULT}
  - fault codes FAULT_NONE=2'b00, FAULT_MISALIGN=2'b01, FAULT_TIMEOUT=2'b10
  - constant INSTR_BYTES=4
- Sub-module fetch_timer: clear/increment counter with an expired output, parameterised by TIMEOUT.

Test Plan:
- Reset with RESET_PC=0x100, enable=1, imem_ack tied 1, imem_rdata=0xDEADBEEF: imem_req high 1 cycle after release, instr=0xDEADBEEF with instr_valid 1 cycle later, pc4=0x104.
- instr_done with next_pc=pc4 over 3 instructions: pc steps 0x100->0x104->0x108->0x10C, retired_count=3.
- In EXEC, next_pc=0x0000_0042 with instr_done: fault=1, fault_code=01, pc remains 0x10C, retired_count unchanged, no further imem_req.
- TIMEOUT=4, imem_ack held 0: imem_req high exactly 4 cycles, then fault_code=10. Repeat with ack on the 4th cycle: no fault, EXEC entered.
- Deassert enable during FETCH with ack after 3 cycles: fetch completes; after instr_done, state IDLE and imem_req=0.
- Assert rst_n=0 mid-FETCH, asynchronously between edges: imem_req=0 and pc=RESET_PC immediately. Also check pc=0xFFFF_FFFC gives pc4=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the fetch front end of the monocycle core.
//   fetch_state_t : sequencer states (IDLE, FETCH, EXEC, FAULT)
//   FAULT_*       : encodings reported on fault_code
//   INSTR_BYTES   : PC increment per instruction
//   timer_width() : bit width of the fetch timeout counter
package core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    FAULT = 2'b11
  } fetch_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  localparam int INSTR_BYTES = 4;

  // Enough bits to hold 0..timeout, never narrower than one bit.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
//   imem_req   : fetch request (fetch unit -> memory)
//   imem_addr  : fetch address (fetch unit -> memory)
//   imem_ack   : imem_rdata valid this cycle (memory -> fetch unit)
//   imem_rdata : instruction word (memory -> fetch unit)
// Modports: master = fetch unit side, slave = memory side.
interface pc_fetch_unit_if #(
  parameter int ADDR_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_fetch_unit_timer.sv
// Fetch timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (has priority over inc)
//   inc        : count one waiting cycle
//   expired    : the current cycle is the last one allowed before timeout;
//                constant 0 when TIMEOUT = 0 (timeout disabled)
module fetch_timer
  import core_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int W = timer_width(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

      logic [W-1:0] count;

      // NOTE: sequential state uses non-blocking assignments only, and the
      // reset branch is in the sensitivity list so it acts without a clock.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (inc) begin
          count <= count + W'(1);
        end
      end

      // count holds the number of cycles already waited, so reaching LAST
      // means this cycle is number TIMEOUT; an ack in it still wins upstream.
      assign expired = (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
//   clk, rst_n    : clock, asynchronous active-low reset
//   enable        : allow new fetches
//   next_pc       : selected next PC from the jump/branch mux
//   pc, pc4       : current PC and pc + 4 (combinational)
//   imem          : instruction-memory bus (master side)
//   instr         : registered instruction to decode
//   instr_valid   : instr is valid and awaiting retirement
//   instr_done    : decode/execute retires instr this cycle
//   fault         : sticky fault flag, cleared only by reset
//   fault_code    : 01 misaligned next_pc, 10 fetch timeout, 00 none
//   retired_count : retired-instruction counter
module pc_fetch_unit
  import core_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [ADDR_W-1:0]       next_pc,
  output logic [ADDR_W-1:0]       pc,
  output logic [ADDR_W-1:0]       pc4,
  pc_fetch_unit_if.master         imem,
  output logic [31:0]             instr,
  output logic                    instr_valid,
  input  logic                    instr_done,
  output logic                    fault,
  output logic [1:0]              fault_code,
  output logic [31:0]             retired_count
);

  fetch_state_t state, state_next;

  logic capture;       // latch imem_rdata into instr
  logic commit;        // retire: load next_pc, bump retired_count
  logic misalign_hit;  // retirement attempted with unaligned next_pc
  logic timeout_hit;   // fetch gave up waiting for ack
  logic timer_expired;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   ((state != FETCH) || imem.imem_ack),
    .inc     (state == FETCH),
    .expired (timer_expired)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    commit       = 1'b0;
    misalign_hit = 1'b0;
    timeout_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_next = FETCH;
      end
      FETCH: begin
        // Ack is checked before the timer so an ack on the last allowed
        // cycle completes the fetch instead of faulting.
        if (imem.imem_ack) begin
          capture    = 1'b1;
          state_next = EXEC;
        end else if (timer_expired) begin
          timeout_hit = 1'b1;
          state_next  = FAULT;
        end
      end
      EXEC: begin
        if (instr_done) begin
          if (|next_pc[1:0]) begin
            misalign_hit = 1'b1;
            state_next   = FAULT;
          end else begin
            commit     = 1'b1;
            state_next = enable ? FETCH : IDLE;
          end
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      instr         <= '0;
      retired_count <= '0;
      fault_code    <= FAULT_NONE;
    end else begin
      if (capture) instr <= imem.imem_rdata;
      if (commit) begin
        pc            <= next_pc;
        retired_count <= retired_count + 32'd1;
      end
      if (misalign_hit) fault_code <= FAULT_MISALIGN;
      if (timeout_hit)  fault_code <= FAULT_TIMEOUT;
    end
  end

  // Status outputs decode straight from the state register, so an
  // asynchronous reset drops imem_req and instr_valid without a clock edge.
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == EXEC);
  assign fault          = (state == FAULT);
  assign pc4            = pc + ADDR_W'(INSTR_BYTES);

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam int          TMO     = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] next_pc;
  logic [31:0] pc, pc4, instr, retired_count;
  logic        instr_valid, instr_done, fault;
  logic [1:0]  fault_code;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit_if #(.ADDR_W(32)) imem_bus ();

  pc_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (RST_PC),
    .TIMEOUT  (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .next_pc       (next_pc),
    .pc            (pc),
    .pc4           (pc4),
    .imem          (imem_bus),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_done    (instr_done),
    .fault         (fault),
    .fault_code    (fault_code),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: what the unit is doing (requesting,
  // holding an instruction, faulted) and the architectural values.
  logic [31:0] m_pc    = RST_PC;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_count = 32'h0;
  logic        m_req   = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_fault = 1'b0;
  logic [1:0]  m_code  = 2'b00;
  int          m_wait  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RST_PC; m_instr <= 32'h0; m_count <= 32'h0;
      m_req <= 1'b0; m_valid <= 1'b0; m_fault <= 1'b0; m_code <= 2'b00; m_wait <= 0;
    end else if (m_fault) begin
      m_req <= 1'b0;
    end else if (m_req) begin
      if (imem_bus.imem_ack) begin
        m_instr <= imem_bus.imem_rdata;
        m_req   <= 1'b0;
        m_valid <= 1'b1;
        m_wait  <= 0;
      end else if (TMO != 0 && m_wait + 1 == TMO) begin
        m_req   <= 1'b0;
        m_fault <= 1'b1;
        m_code  <= 2'b10;
      end else begin
        m_wait <= m_wait + 1;
      end
    end else if (m_valid) begin
      if (instr_done) begin
        m_valid <= 1'b0;
        if (next_pc[1:0] != 2'b00) begin
          m_fault <= 1'b1;
          m_code  <= 2'b01;
        end else begin
          m_pc    <= next_pc;
          m_count <= m_count + 32'd1;
          m_req   <= enable;
        end
      end
    end else begin
      m_req <= enable;
    end
  end

  always @(negedge clk) begin
    check("pc",            pc,                     m_pc);
    check("pc4",           pc4,                    m_pc + 32'd4);
    check("imem_addr",     imem_bus.imem_addr,     m_pc);
    check("imem_req",      32'(imem_bus.imem_req), 32'(m_req));
    check("instr",         instr,                  m_instr);
    check("instr_valid",   32'(instr_valid),       32'(m_valid));
    check("fault",         32'(fault),             32'(m_fault));
    check("fault_code",    32'(fault_code),        32'(m_code));
    check("retired_count", retired_count,          m_count);
  end

  // Returns at a falling edge with instr_valid high, or flags a timeout.
  task automatic wait_valid(input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic retire(input logic [31:0] np);
    wait_valid("wait_valid");
    instr_done = 1'b1;
    next_pc    = np;
    @(negedge clk);
    instr_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    enable = 1'b1;
    next_pc = 32'h0;
    instr_done = 1'b0;
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;

    // Reset state
    @(posedge clk); #1;
    check("rst_pc",    pc,                     32'h0000_0100);
    check("rst_req",   32'(imem_bus.imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid),       32'd0);
    check("rst_instr", instr,                  32'd0);
    check("rst_count", retired_count,          32'd0);

    // First fetch: req one cycle after release, instr one cycle later
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 32'(imem_bus.imem_req), 32'd1);
    check("first_pc4", pc4,                    32'h0000_0104);
    @(negedge clk);
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_instr", instr,            32'hDEAD_BEEF);

    // Three sequential retirements
    retire(32'h0000_0104);
    retire(32'h0000_0108);
    retire(32'h0000_010C);
    check("seq_pc",    pc,            32'h0000_010C);
    check("seq_count", retired_count, 32'd3);

    // Misaligned next_pc faults and freezes
    retire(32'h0000_0042);
    check("mis_fault", 32'(fault),      32'd1);
    check("mis_code",  32'(fault_code), 32'd1);
    check("mis_pc",    pc,              32'h0000_010C);
    check("mis_count", retired_count,   32'd3);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n += int'(imem_bus.imem_req);
    end
    check("mis_no_req", 32'(n), 32'd0);

    // Timeout: exactly TMO request cycles, then fault 10
    imem_bus.imem_ack = 1'b0;
    do_reset();
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(imem_bus.imem_req);
    end
    check("tmo_req_cycles", 32'(n),          32'd4);
    check("tmo_code",       32'(fault_code), 32'd2);

    // Ack in the 4th request cycle wins over the timeout
    imem_bus.imem_rdata = 32'h1234_5678;
    do_reset();
    @(negedge clk);
    check("late_req1", 32'(imem_bus.imem_req), 32'd1);
    repeat (3) @(negedge clk);
    imem_bus.imem_ack = 1'b1;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    check("late_valid", 32'(instr_valid), 32'd1);
    check("late_fault", 32'(fault),       32'd0);
    check("late_instr", instr,            32'h1234_5678);

    // enable dropped mid-fetch: fetch completes, then IDLE after retire
    imem_bus.imem_rdata = 32'h0000_0013;
    retire(32'h0000_0104);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    imem_bus.imem_ack = 1'b1;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    check("en_valid", 32'(instr_valid), 32'd1);
    check("en_instr", instr,            32'h0000_0013);
    retire(32'h0000_0108);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      n += int'(imem_bus.imem_req) + int'(instr_valid);
    end
    check("en_idle", 32'(n), 32'd0);
    check("en_pc",   pc,     32'h0000_0108);

    // pc4 wraps to zero at the top of the address space
    enable = 1'b1;
    imem_bus.imem_ack = 1'b1;
    retire(32'hFFFF_FFFC);
    check("wrap_pc",  pc,  32'hFFFF_FFFC);
    check("wrap_pc4", pc4, 32'h0000_0000);

    // next_pc = 0 is legal; then reset asynchronously mid-fetch
    wait_valid("wait_valid");
    imem_bus.imem_ack = 1'b0;
    retire(32'h0000_0000);
    check("zero_pc",  pc,                     32'h0000_0000);
    check("zero_req", 32'(imem_bus.imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_req", 32'(imem_bus.imem_req), 32'd0);
    check("async_pc",  pc,                     32'h0000_0100);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
